// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_WIDTH data bits LSB first,
// optional even/odd parity, one or two stop bits, each CLOCKS_PER_BIT cycles.
module uart_tx_cfg #(
    parameter int DATA_WIDTH     = 8,
    parameter int CLOCKS_PER_BIT = 10417,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  uart_tx,
    output logic                  busy,
    output logic                  tx_done,
    output logic [2:0]            o_dbg_state
);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
        $error("uart_tx_cfg: DATA_WIDTH must be 5..9");
    end
    if (CLOCKS_PER_BIT < 2) begin : g_bad_clocks_per_bit
        $error("uart_tx_cfg: CLOCKS_PER_BIT must be >= 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
        $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic                  r_tx;
    logic                  r_done;
    logic                  w_bit_end;

    // Handshake: a byte is accepted on the rising edge where s_valid && s_ready;
    // s_ready is high exactly while the FSM sits in IDLE, and s_data is only
    // sampled on that edge.
    assign w_bit_end   = (r_cnt == CNT_LAST);
    assign s_ready     = (r_state == S_IDLE);
    assign busy        = ~s_ready;
    assign uart_tx     = r_tx;
    assign tx_done     = r_done;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx  <= 1'b1;
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (s_valid) begin
                        r_shift <= s_data;
                        // Parity is fixed at accept time so later shifting cannot disturb it.
                        r_par   <= (PARITY_MODE == 2) ? ~(^s_data) : (^s_data);
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_idx <= '0;
                            if (PARITY_MODE != 0) begin
                                r_tx    <= r_par;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_tx    <= r_shift[1];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == STOP_LAST) begin
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four instances (no parity, even, odd, two stop bits)
// at CLOCKS_PER_BIT=4; expected frames are pushed on issue and checked per cycle.
module tb_uart_tx_cfg;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       s_valid [4];
    logic [7:0] s_data  [4];
    logic       w_tx    [4];
    logic       w_ready [4];
    logic       w_busy  [4];
    logic       w_done  [4];
    logic [2:0] w_dbg   [4];

    // {dut[1:0], len[3:0], frame bits in time order, first bit is most significant of len}
    logic [21:0] exp_q[$];
    int          vecs;
    int          fails;
    int          mon_active;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_cfg #(
            .DATA_WIDTH    (8),
            .CLOCKS_PER_BIT(CPB),
            .PARITY_MODE   ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
            .STOP_BITS     ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .s_valid    (s_valid[g]),
            .s_data     (s_data[g]),
            .s_ready    (w_ready[g]),
            .uart_tx    (w_tx[g]),
            .busy       (w_busy[g]),
            .tx_done    (w_done[g]),
            .o_dbg_state(w_dbg[g])
        );
    end

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int len, input logic [15:0] bits);
        logic [1:0] kk;
        logic [3:0] ll;
        kk = k[1:0];
        ll = len[3:0];
        exp_q.push_back({kk, ll, bits});
    endtask

    // Driver: present a byte and hold it until accepted.
    task automatic send(input int k, input logic [7:0] d, input bit keep, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        s_data[k]  = d;
        s_valid[k] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            waited++;
            if (w_ready[k]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check($sformatf("accept_timeout_dut%0d", k), 32'd0, 32'd1);
            s_valid[k] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (!keep) s_valid[k] = 1'b0;
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && mon_active == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: on each accept, pop the expected frame and check every cycle
    // of it plus the tx_done cycle. {tx, done, ready, busy} per cycle.
    task automatic mon(input int k);
        logic [21:0] e;
        int          len;
        bit          pend;
        logic [3:0]  exp_v;
        pend = 0;
        forever begin
            if (!pend) begin
                @(negedge clk);
                if (!(s_valid[k] && w_ready[k] && !rst)) continue;
            end
            pend = 0;
            if (exp_q.size() == 0) begin
                check($sformatf("unexpected_accept_dut%0d", k), 32'd1, 32'd0);
                continue;
            end
            e = exp_q.pop_front();
            mon_active++;
            check($sformatf("frame_dut%0d", k), 32'(k), 32'(e[21:20]));
            len = int'(e[19:16]);
            for (int c = 1; c <= len * CPB + 1; c++) begin
                @(negedge clk);
                if (rst) break;
                if (c <= len * CPB)
                    exp_v = {e[len - 1 - (c - 1) / CPB], 1'b0, 1'b0, 1'b1};
                else
                    exp_v = 4'b1110;
                check($sformatf("dut%0d_cycle%0d_tx_done_ready_busy", k, c),
                      32'({w_tx[k], w_done[k], w_ready[k], w_busy[k]}), 32'(exp_v));
                if (c == len * CPB + 1 && s_valid[k]) pend = 1;
            end
            mon_active--;
        end
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
            mon(2);
            mon(3);
        join_none
    end

    initial begin
        int   w;
        logic any_done;
        vecs       = 0;
        fails      = 0;
        mon_active = 0;
        rst        = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_valid[k] = 1'b0;
            s_data[k]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_outputs_dut%0d", k),
                  32'({w_tx[k], w_done[k], w_ready[k], w_busy[k]}), 32'(4'b1010));
            check($sformatf("reset_state_dut%0d", k), 32'(w_dbg[k]), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic frame, no parity
        push(0, 10, 16'(10'b0_10100101_1));
        send(0, 8'hA5, 0, w);
        drain();

        // Parity and two stop bits
        push(1, 11, 16'(11'b0_11100000_1_1));
        send(1, 8'h07, 0, w);
        drain();
        push(2, 11, 16'(11'b0_11100000_0_1));
        send(2, 8'h07, 0, w);
        drain();
        push(1, 11, 16'(11'b0_00000000_0_1));
        send(1, 8'h00, 0, w);
        drain();
        push(2, 11, 16'(11'b0_00000000_1_1));
        send(2, 8'h00, 0, w);
        drain();
        push(3, 11, 16'(11'b0_11111111_11));
        send(3, 8'hFF, 0, w);
        drain();

        // Back-to-back with s_valid held; data changes right after the first accept
        push(0, 10, 16'(10'b0_10000000_1));
        push(0, 10, 16'(10'b0_00000001_1));
        send(0, 8'h01, 1, w);
        send(0, 8'h80, 0, w);
        check("b2b_second_accept_cycle", 32'(w), 32'd41);
        drain();

        // Asynchronous reset during data bit 3, then a clean frame
        push(0, 10, 16'(10'b0_01011010_1));
        send(0, 8'h5A, 0, w);
        repeat (17) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_async_tx_done_ready_busy",
              32'({w_tx[0], w_done[0], w_ready[0], w_busy[0]}), 32'(4'b1010));
        check("rst_async_state", 32'(w_dbg[0]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        any_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            any_done = any_done | w_done[0];
        end
        check("rst_no_tx_done", 32'(any_done), 32'd0);
        push(0, 10, 16'(10'b0_00111100_1));
        send(0, 8'h3C, 0, w);
        drain();

        // s_valid pulse while busy is ignored
        push(0, 10, 16'(10'b0_01000100_1));
        send(0, 8'h22, 0, w);
        repeat (9) @(posedge clk);
        #1;
        s_data[0]  = 8'h11;
        s_valid[0] = 1'b1;
        @(negedge clk);
        check("busy_ready_low", 32'(w_ready[0]), 32'd0);
        @(posedge clk);
        #1 s_valid[0] = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter CLOCKS_PER_BIT, default 10417: clk cycles per serial bit (100 MHz / 9600 baud), minimum 2.
REQ-003 SHALL have parameter PARITY_MODE, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1: 1 or 2 stop bits.
REQ-005 SHALL fail elaboration if any parameter is outside its legal range.
REQ-006 clk  input  1  one clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 s_valid  input  1  source has a byte to send.
REQ-009 s_data  input  DATA_WIDTH  byte to send; sampled only on accept.
REQ-010 s_ready  output  1  block can accept a byte this cycle.
REQ-011 uart_tx  output  1  serial line; idle high, registered.
REQ-012 busy  output  1  frame in progress.
REQ-013 tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-015 Accept SHALL occur when s_valid && s_ready; s_ready SHALL be high only in IDLE.
REQ-016 On accept, s_data SHALL be latched internally; s_data changes after accept SHALL have no effect on the frame.
REQ-017 The accept cycle SHALL be cycle 0; uart_tx SHALL go low from cycle 1 (IDLE->START).
REQ-018 Each start, data, parity and stop bit SHALL be held on uart_tx for exactly CLOCKS_PER_BIT cycles, timed by a bit counter of width $clog2(CLOCKS_PER_BIT) that wraps to 0 at CLOCKS_PER_BIT-1.
REQ-019 Data bits SHALL be sent LSB first, using a bit index of width $clog2(DATA_WIDTH+1).
REQ-020 Transitions: START->DATA after 1 bit period; DATA->PARITY after DATA_WIDTH bit periods if PARITY_MODE != 0, otherwise DATA->STOP; PARITY->STOP after 1 bit period; STOP->IDLE after STOP_BITS bit periods.
REQ-021 Parity bit SHALL be the XOR of the latched data for even parity and its inverse for odd parity.
REQ-022 Stop bits and IDLE SHALL drive uart_tx high.
REQ-023 tx_done SHALL pulse high for exactly the first IDLE cycle after STOP; s_ready SHALL be high in that same cycle.
REQ-024 Back-to-back: with s_valid held high, the next accept SHALL occur in the tx_done cycle, giving one idle-high cycle between frames.
REQ-025 busy SHALL equal !s_ready.
REQ-026 s_valid while busy SHALL be ignored, with no loss or corruption of the current frame.
REQ-027 Total frame length SHALL be (1 + DATA_WIDTH + (PARITY_MODE != 0) + STOP_BITS) * CLOCKS_PER_BIT cycles.

Reset
REQ-028 While rst is high, outputs SHALL be uart_tx = 1, s_ready = 1, busy = 0, tx_done = 0; state SHALL be IDLE; bit counter and bit index SHALL be 0.
REQ-029 rst asserted mid-frame SHALL abort the frame immediately without waiting for a clock edge; no tx_done SHALL pulse for the aborted frame.
REQ-030 The first frame after rst deasserts SHALL be bit-exact.

Verification (CLOCKS_PER_BIT = 4 unless stated)
REQ-031 DATA_WIDTH=8, PARITY_MODE=0, STOP_BITS=1, accept 0xA5 at cycle 0 -> uart_tx low cycles 1-4, bits 1,0,1,0,0,1,0,1 for 4 cycles each (cycles 5-36), high cycles 37-40, tx_done and s_ready high at cycle 41.
REQ-032 PARITY_MODE=1, send 0x07 -> parity bit 1 in cycles 37-40, tx_done at cycle 45; PARITY_MODE=2, send 0x07 -> parity bit 0.
REQ-033 STOP_BITS=2, PARITY_MODE=0, send 0xFF -> uart_tx high cycles 37-44, tx_done at cycle 45.
REQ-034 s_valid held high with 0x01 then 0x80 -> second accept at cycle 41, second start bit low cycles 42-45, second frame data bits 0,0,0,0,0,0,0,1.
REQ-035 rst pulsed during data bit 3 of 0x5A -> uart_tx = 1 immediately, s_ready = 1, no tx_done; next frame 0x3C is bit-exact per REQ-031 timing.
REQ-036 s_valid pulsed with 0x11 at cycle 10 of a frame carrying 0x22 -> s_ready = 0, 0x11 not sent, 0x22 frame unchanged.
